// File: rtl/axi_rd_arbiter_2m2s.sv
// axi_rd_arbiter_2m2s
//   Control plane for a shared 2-master x 2-slave AXI read interconnect.
//   It decodes each master's AR address against programmable slave windows,
//   arbitrates each slave round-robin, and drives the select lines and the
//   gated VALID/READY signals of the external AR/R datapath muxes.
//   Each master and each slave has at most one read outstanding.
//
// Ports
//   clkk, resett                  clock; asynchronous active-low reset
//   slaveN_addr1/slaveN_addr2     inclusive address window of slave N
//   Mm_ARVALID/Mm_ARADDR          master AR request
//   Sn_ARREADY                    slave AR ready
//   Sn_RVALID/Sn_RLAST            slave R beat valid / last beat
//   Mm_RREADY                     master R ready
//   Sn_ARVALID, Sn_ar_sel         gated AR valid and AR mux select (0=M0, 1=M1)
//   Mm_ARREADY                    gated AR ready to the master
//   Mm_r_sel, Mm_RVALID           R mux select (0=S0, 1=S1) and gated R valid
//   Sn_RREADY                     gated R ready to the slave
//   Mm_decerr                     one-cycle pulse: unmapped request dropped
//   dbg_state                     {drop1, drop0, slave1 state, slave0 state}
//
// Handshake: a transfer happens on a cycle where VALID and READY are both 1
// at the rising clock edge. The gated signals simply forward the owner's
// VALID/READY, so the handshake seen by each end is exactly that of the other.
module axi_rd_arbiter_2m2s #(
  parameter int AW               = 32,
  parameter int NUM_SLAVES_FIXED = 2
) (
  input  logic                            clkk,
  input  logic                            resett,
  input  logic [AW-1:0]                   slave0_addr1,
  input  logic [AW-1:0]                   slave0_addr2,
  input  logic [AW-1:0]                   slave1_addr1,
  input  logic [AW-1:0]                   slave1_addr2,
  input  logic                            M0_ARVALID,
  input  logic                            M1_ARVALID,
  input  logic [AW-1:0]                   M0_ARADDR,
  input  logic [AW-1:0]                   M1_ARADDR,
  input  logic                            S0_ARREADY,
  input  logic                            S1_ARREADY,
  input  logic                            S0_RVALID,
  input  logic                            S1_RVALID,
  input  logic                            S0_RLAST,
  input  logic                            S1_RLAST,
  input  logic                            M0_RREADY,
  input  logic                            M1_RREADY,
  output logic                            S0_ARVALID,
  output logic                            S1_ARVALID,
  output logic                            S0_ar_sel,
  output logic                            S1_ar_sel,
  output logic                            M0_ARREADY,
  output logic                            M1_ARREADY,
  output logic                            M0_r_sel,
  output logic                            M1_r_sel,
  output logic                            M0_RVALID,
  output logic                            M1_RVALID,
  output logic                            S0_RREADY,
  output logic                            S1_RREADY,
  output logic                            M0_decerr,
  output logic                            M1_decerr,
  output logic [3*NUM_SLAVES_FIXED-1:0]   dbg_state
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ADDR = 2'd1, S_DATA = 2'd2} slv_state_t;
  typedef enum logic       {D_IDLE = 1'b0, D_DROP = 1'b1} drop_state_t;

  // Bit m of these vectors belongs to master m, bit x to slave x.
  logic [1:0]      arvalid, rready, s_arready, s_rvalid, s_rlast;
  logic [AW-1:0]   araddr [2];
  logic [1:0]      hit0, hit1, unmapped, busy;
  logic [1:0][1:0] tgt;    // tgt[x][m]: master m decodes to slave x
  logic [1:0][1:0] req;    // req[x][m]: master m may be granted slave x now

  slv_state_t      st [2];
  slv_state_t      st_nxt [2];
  logic [1:0]      own, own_nxt, ptr, ptr_nxt;
  drop_state_t     drop [2];
  drop_state_t     drop_nxt [2];

  logic [1:0]      o_s_arvalid, o_s_ar_sel, o_m_arready, o_m_r_sel, o_m_rvalid, o_s_rready;

  assign arvalid   = {M1_ARVALID, M0_ARVALID};
  assign rready    = {M1_RREADY, M0_RREADY};
  assign s_arready = {S1_ARREADY, S0_ARREADY};
  assign s_rvalid  = {S1_RVALID, S0_RVALID};
  assign s_rlast   = {S1_RLAST, S0_RLAST};
  assign araddr[0] = M0_ARADDR;
  assign araddr[1] = M1_ARADDR;

  // Address decode; S0 takes priority where the two windows overlap.
  always_comb begin
    hit0     = '0;
    hit1     = '0;
    tgt      = '0;
    unmapped = '0;
    for (int m = 0; m < 2; m++) begin
      hit0[m]     = (araddr[m] >= slave0_addr1) && (araddr[m] <= slave0_addr2);
      hit1[m]     = (araddr[m] >= slave1_addr1) && (araddr[m] <= slave1_addr2);
      tgt[0][m]   = hit0[m];
      tgt[1][m]   = ~hit0[m] & hit1[m];
      unmapped[m] = ~hit0[m] & ~hit1[m];
    end
  end

  // A master owning any slave (address or data phase) cannot be granted again.
  always_comb begin
    busy = '0;
    for (int x = 0; x < 2; x++) begin
      if (st[x] != S_IDLE) busy[own[x]] = 1'b1;
    end
  end

  always_comb begin
    req     = '0;
    own_nxt = own;
    ptr_nxt = ptr;
    for (int x = 0; x < 2; x++) begin
      st_nxt[x] = st[x];
      req[x]    = arvalid & tgt[x] & ~busy;
      case (st[x])
        S_IDLE: begin
          if (req[x] == 2'b11) begin
            // Contested: the pointer wins and then hands priority over.
            own_nxt[x] = ptr[x];
            ptr_nxt[x] = ~ptr[x];
            st_nxt[x]  = S_ADDR;
          end else if (req[x] != 2'b00) begin
            own_nxt[x] = req[x][1];
            st_nxt[x]  = S_ADDR;
          end
        end
        // A master dropping ARVALID here simply keeps the slave in ADDR.
        S_ADDR: if (arvalid[own[x]] && s_arready[x]) st_nxt[x] = S_DATA;
        S_DATA: if (s_rvalid[x] && rready[own[x]] && s_rlast[x]) st_nxt[x] = S_IDLE;
        default: st_nxt[x] = S_IDLE;
      endcase
    end
    for (int m = 0; m < 2; m++) begin
      drop_nxt[m] = (drop[m] == D_IDLE && arvalid[m] && unmapped[m] && !busy[m])
                    ? D_DROP : D_IDLE;
    end
  end

  always_ff @(posedge clkk or negedge resett) begin
    if (!resett) begin
      for (int x = 0; x < 2; x++) begin
        st[x]   <= S_IDLE;
        drop[x] <= D_IDLE;
      end
      own <= '0;
      ptr <= '0;
    end else begin
      for (int x = 0; x < 2; x++) begin
        st[x]   <= st_nxt[x];
        drop[x] <= drop_nxt[x];
      end
      own <= own_nxt;
      ptr <= ptr_nxt;
    end
  end

  // Output steering. Everything defaults to 0 so an unowned slave or an
  // idle master sees no valid, no ready and select 0.
  always_comb begin
    o_s_arvalid = '0;
    o_s_ar_sel  = '0;
    o_m_arready = '0;
    o_m_r_sel   = '0;
    o_m_rvalid  = '0;
    o_s_rready  = '0;
    for (int x = 0; x < 2; x++) begin
      if (st[x] == S_ADDR) begin
        o_s_arvalid[x]      = arvalid[own[x]];
        o_s_ar_sel[x]       = own[x];
        o_m_arready[own[x]] = s_arready[x];
      end else if (st[x] == S_DATA) begin
        o_m_r_sel[own[x]]   = (x == 1);
        o_m_rvalid[own[x]]  = s_rvalid[x];
        o_s_rready[x]       = rready[own[x]];
      end
    end
    // The dropped request is completed locally with a single ARREADY pulse.
    for (int m = 0; m < 2; m++) begin
      if (drop[m] == D_DROP) o_m_arready[m] = 1'b1;
    end
  end

  assign S0_ARVALID = o_s_arvalid[0];
  assign S1_ARVALID = o_s_arvalid[1];
  assign S0_ar_sel  = o_s_ar_sel[0];
  assign S1_ar_sel  = o_s_ar_sel[1];
  assign M0_ARREADY = o_m_arready[0];
  assign M1_ARREADY = o_m_arready[1];
  assign M0_r_sel   = o_m_r_sel[0];
  assign M1_r_sel   = o_m_r_sel[1];
  assign M0_RVALID  = o_m_rvalid[0];
  assign M1_RVALID  = o_m_rvalid[1];
  assign S0_RREADY  = o_s_rready[0];
  assign S1_RREADY  = o_s_rready[1];
  assign M0_decerr  = (drop[0] == D_DROP);
  assign M1_decerr  = (drop[1] == D_DROP);
  assign dbg_state  = {drop[1], drop[0], st[1], st[0]};

endmodule

// File: tb/tb_axi_rd_arbiter_2m2s.sv
// Self-checking bench for axi_rd_arbiter_2m2s: directed scenarios followed by
// randomized traffic, all compared every cycle against a transaction-level
// model of slave ownership, round-robin priority and dropped requests.
module tb_axi_rd_arbiter_2m2s;

  // ---------------- clock / reset ----------------
  logic clkk = 1'b0;
  logic resett = 1'b0;
  always #5 clkk = ~clkk;

  // ---------------- stimulus variables ----------------
  logic [31:0] r0lo, r0hi, r1lo, r1hi;
  logic        arv [2];
  logic [31:0] addr [2];
  logic        sarr [2];
  logic        srv [2];
  logic        slast [2];
  logic        mrr [2];

  logic S0_ARVALID, S1_ARVALID, S0_ar_sel, S1_ar_sel, M0_ARREADY, M1_ARREADY;
  logic M0_r_sel, M1_r_sel, M0_RVALID, M1_RVALID, S0_RREADY, S1_RREADY;
  logic M0_decerr, M1_decerr;
  logic [5:0] dbg_state;

  axi_rd_arbiter_2m2s #(.AW(32), .NUM_SLAVES_FIXED(2)) dut (
    .clkk(clkk), .resett(resett),
    .slave0_addr1(r0lo), .slave0_addr2(r0hi),
    .slave1_addr1(r1lo), .slave1_addr2(r1hi),
    .M0_ARVALID(arv[0]), .M1_ARVALID(arv[1]),
    .M0_ARADDR(addr[0]), .M1_ARADDR(addr[1]),
    .S0_ARREADY(sarr[0]), .S1_ARREADY(sarr[1]),
    .S0_RVALID(srv[0]), .S1_RVALID(srv[1]),
    .S0_RLAST(slast[0]), .S1_RLAST(slast[1]),
    .M0_RREADY(mrr[0]), .M1_RREADY(mrr[1]),
    .S0_ARVALID(S0_ARVALID), .S1_ARVALID(S1_ARVALID),
    .S0_ar_sel(S0_ar_sel), .S1_ar_sel(S1_ar_sel),
    .M0_ARREADY(M0_ARREADY), .M1_ARREADY(M1_ARREADY),
    .M0_r_sel(M0_r_sel), .M1_r_sel(M1_r_sel),
    .M0_RVALID(M0_RVALID), .M1_RVALID(M1_RVALID),
    .S0_RREADY(S0_RREADY), .S1_RREADY(S1_RREADY),
    .M0_decerr(M0_decerr), .M1_decerr(M1_decerr),
    .dbg_state(dbg_state)
  );

  // ---------------- reference model ----------------
  // phase per slave: 0 free, 1 address phase, 2 data phase
  int  ph [2];
  int  owner [2];
  int  rr [2];
  bit  drop_pend [2];
  logic e_sarv [2], e_sarsel [2], e_marr [2], e_mrsel [2], e_mrv [2], e_srr [2], e_dec [2];

  int n_asserts = 0;
  int n_fail = 0;

  function automatic int target(input logic [31:0] a);
    if (a >= r0lo && a <= r0hi) return 0;
    if (a >= r1lo && a <= r1hi) return 1;
    return -1;
  endfunction

  function automatic bit master_busy(input int m);
    for (int x = 0; x < 2; x++)
      if (ph[x] != 0 && owner[x] == m) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      ph[i] = 0; owner[i] = 0; rr[i] = 0; drop_pend[i] = 1'b0;
    end
  endtask

  task automatic model_outputs();
    for (int i = 0; i < 2; i++) begin
      e_sarv[i] = 0; e_sarsel[i] = 0; e_marr[i] = 0;
      e_mrsel[i] = 0; e_mrv[i] = 0; e_srr[i] = 0; e_dec[i] = 0;
    end
    for (int x = 0; x < 2; x++) begin
      if (ph[x] == 1) begin
        e_sarv[x] = arv[owner[x]];
        e_sarsel[x] = (owner[x] == 1);
        if (sarr[x]) e_marr[owner[x]] = 1;
      end else if (ph[x] == 2) begin
        e_mrsel[owner[x]] = (x == 1);
        e_mrv[owner[x]] = srv[x];
        e_srr[x] = mrr[owner[x]];
      end
    end
    for (int m = 0; m < 2; m++)
      if (drop_pend[m]) begin e_marr[m] = 1; e_dec[m] = 1; end
  endtask

  int  n_ph [2], n_own [2], n_rr [2];
  bit  n_drop [2];

  task automatic model_next();
    int q[$];
    for (int x = 0; x < 2; x++) begin
      n_ph[x] = ph[x]; n_own[x] = owner[x]; n_rr[x] = rr[x];
      case (ph[x])
        0: begin
          q.delete();
          for (int m = 0; m < 2; m++)
            if (arv[m] && target(addr[m]) == x && !master_busy(m)) q.push_back(m);
          if (q.size() == 1) begin
            n_own[x] = q[0]; n_ph[x] = 1;
          end else if (q.size() == 2) begin
            n_own[x] = rr[x]; n_rr[x] = 1 - rr[x]; n_ph[x] = 1;
          end
        end
        1: if (arv[owner[x]] && sarr[x]) n_ph[x] = 2;
        default: if (srv[x] && mrr[owner[x]] && slast[x]) n_ph[x] = 0;
      endcase
    end
    for (int m = 0; m < 2; m++)
      n_drop[m] = !drop_pend[m] && arv[m] && target(addr[m]) == -1 && !master_busy(m);
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("S0_ARVALID", S0_ARVALID, e_sarv[0]);
    chk("S1_ARVALID", S1_ARVALID, e_sarv[1]);
    chk("S0_ar_sel", S0_ar_sel, e_sarsel[0]);
    chk("S1_ar_sel", S1_ar_sel, e_sarsel[1]);
    chk("M0_ARREADY", M0_ARREADY, e_marr[0]);
    chk("M1_ARREADY", M1_ARREADY, e_marr[1]);
    chk("M0_r_sel", M0_r_sel, e_mrsel[0]);
    chk("M1_r_sel", M1_r_sel, e_mrsel[1]);
    chk("M0_RVALID", M0_RVALID, e_mrv[0]);
    chk("M1_RVALID", M1_RVALID, e_mrv[1]);
    chk("S0_RREADY", S0_RREADY, e_srr[0]);
    chk("S1_RREADY", S1_RREADY, e_srr[1]);
    chk("M0_decerr", M0_decerr, e_dec[0]);
    chk("M1_decerr", M1_decerr, e_dec[1]);
  endtask

  // ---------------- driver tasks ----------------
  // settle: let the current inputs propagate and compare against the model.
  task automatic settle();
    #1;
    if (!resett) model_reset();
    model_outputs();
    compare_all();
  endtask

  // advance: move model and DUT across one rising edge; returns 1ns after it.
  task automatic advance();
    model_next();
    @(posedge clkk);
    if (resett) begin
      for (int i = 0; i < 2; i++) begin
        ph[i] = n_ph[i]; owner[i] = n_own[i]; rr[i] = n_rr[i]; drop_pend[i] = n_drop[i];
      end
    end else begin
      model_reset();
    end
    #1;
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < 2; i++) begin
      arv[i] = 0; addr[i] = 0; sarr[i] = 0; srv[i] = 0; slast[i] = 0; mrr[i] = 0;
    end
  endtask

  task automatic reset_dut();
    clear_inputs();
    resett = 1'b0;
    settle();
    chk("rst_dbg_state", dbg_state, 6'd0);
    advance();
    advance();
    resett = 1'b1;
    settle();
    advance();
  endtask

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 9))
      0: return $urandom_range(32'h0, 32'hFFF);
      1: return $urandom_range(32'h1000, 32'h1FFF);
      2: return $urandom_range(32'h2000, 32'h8000);
      3: return 32'hFFF;
      4: return 32'h1000;
      5: return 32'h1FFF;
      6: return 32'h2000;
      7: return 32'h0;
      8: return $urandom_range(32'h700, 32'h1900);
      default: return $urandom_range(32'h0, 32'h2FFF);
    endcase
  endfunction

  task automatic random_phase(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      for (int i = 0; i < 2; i++) begin
        arv[i]   = ($urandom_range(0, 3) != 0);
        addr[i]  = pick_addr();
        sarr[i]  = $urandom_range(0, 1);
        srv[i]   = $urandom_range(0, 1);
        slast[i] = ($urandom_range(0, 2) == 0);
        mrr[i]   = ($urandom_range(0, 3) != 0);
      end
      if ($urandom_range(0, 400) == 0) resett = 1'b0;
      settle();
      advance();
      resett = 1'b1;
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    r0lo = 32'h0; r0hi = 32'hFFF; r1lo = 32'h1000; r1hi = 32'h1FFF;
    clear_inputs();
    model_reset();
    reset_dut();

    // 1: single M0 read to S0, 4-beat burst
    arv[0] = 1; addr[0] = 32'h100; sarr[0] = 1;
    settle(); chk("t1_idle_s0_arvalid", S0_ARVALID, 0); advance();
    settle(); chk("t1_s0_arvalid", S0_ARVALID, 1); chk("t1_s0_ar_sel", S0_ar_sel, 0);
    chk("t1_m0_arready", M0_ARREADY, 1); advance();
    arv[0] = 0; sarr[0] = 0; mrr[0] = 1;
    for (int b = 0; b < 4; b++) begin
      srv[0] = 1; slast[0] = (b == 3);
      settle(); chk("t1_m0_rvalid", M0_RVALID, 1); chk("t1_m0_r_sel", M0_r_sel, 0);
      chk("t1_s0_data", dbg_state[1:0], 2'd2); advance();
    end
    srv[0] = 0; slast[0] = 0;
    settle(); chk("t1_s0_idle", dbg_state[1:0], 2'd0); advance();

    // 2: contention on S1, round-robin
    reset_dut();
    arv[0] = 1; addr[0] = 32'h1000; arv[1] = 1; addr[1] = 32'h1FFF; sarr[1] = 1;
    settle(); advance();
    settle(); chk("t2_first_sel", S1_ar_sel, 0); chk("t2_s1_arvalid", S1_ARVALID, 1);
    chk("t2_m0_arready", M0_ARREADY, 1); chk("t2_m1_arready", M1_ARREADY, 0); advance();
    arv[0] = 0; srv[1] = 1; slast[1] = 1; mrr[0] = 1; mrr[1] = 1;
    settle(); chk("t2_m0_rvalid", M0_RVALID, 1); chk("t2_m0_r_sel", M0_r_sel, 1);
    chk("t2_m1_wait_arready", M1_ARREADY, 0); chk("t2_m1_rvalid", M1_RVALID, 0); advance();
    srv[1] = 0; slast[1] = 0;
    settle(); chk("t2_rearb_arvalid", S1_ARVALID, 0); advance();
    settle(); chk("t2_m1_sel", S1_ar_sel, 1); chk("t2_m1_arready_g", M1_ARREADY, 1); advance();
    arv[1] = 0; srv[1] = 1; slast[1] = 1;
    settle(); chk("t2_m1_rvalid_g", M1_RVALID, 1); chk("t2_m1_r_sel", M1_r_sel, 1); advance();
    srv[1] = 0; slast[1] = 0;
    arv[0] = 1; addr[0] = 32'h1004; arv[1] = 1; addr[1] = 32'h1008;
    settle(); advance();
    settle(); chk("t2_second_contest", S1_ar_sel, 1); advance();

    // 3: concurrent M0->S0 and M1->S1
    reset_dut();
    arv[0] = 1; addr[0] = 32'h200; arv[1] = 1; addr[1] = 32'h1200;
    sarr[0] = 1; sarr[1] = 1; mrr[0] = 1; mrr[1] = 1;
    settle(); advance();
    settle(); chk("t3_s0_arvalid", S0_ARVALID, 1); chk("t3_s0_sel", S0_ar_sel, 0);
    chk("t3_s1_arvalid", S1_ARVALID, 1); chk("t3_s1_sel", S1_ar_sel, 1); advance();
    arv[0] = 0; arv[1] = 0;
    srv[0] = 1; slast[0] = 0; srv[1] = 0;
    settle(); chk("t3a_m0_rvalid", M0_RVALID, 1); chk("t3a_m1_rvalid", M1_RVALID, 0);
    chk("t3a_m0_r_sel", M0_r_sel, 0); chk("t3a_m1_r_sel", M1_r_sel, 1); advance();
    srv[0] = 0; srv[1] = 1; slast[1] = 1;
    settle(); chk("t3b_m1_rvalid", M1_RVALID, 1); chk("t3b_m0_rvalid", M0_RVALID, 0);
    chk("t3b_m1_r_sel", M1_r_sel, 1); advance();
    srv[0] = 1; slast[0] = 1; srv[1] = 0; slast[1] = 0;
    settle(); chk("t3c_m0_rvalid", M0_RVALID, 1); chk("t3c_m1_r_sel_idle", M1_r_sel, 0); advance();
    srv[0] = 0; slast[0] = 0;
    settle(); chk("t3_both_idle", dbg_state[3:0], 4'd0); advance();

    // 4: unmapped request from M1
    reset_dut();
    arv[1] = 1; addr[1] = 32'h5000; sarr[0] = 1; sarr[1] = 1;
    settle(); chk("t4_pre_decerr", M1_decerr, 0); advance();
    settle(); chk("t4_arready", M1_ARREADY, 1); chk("t4_decerr", M1_decerr, 1);
    chk("t4_s0_arvalid", S0_ARVALID, 0); chk("t4_s1_arvalid", S1_ARVALID, 0); advance();
    arv[1] = 0;
    settle(); chk("t4_decerr_end", M1_decerr, 0); chk("t4_arready_end", M1_ARREADY, 0); advance();

    // 5: RLAST held while master not ready
    reset_dut();
    arv[0] = 1; addr[0] = 32'h40; sarr[0] = 1;
    settle(); advance();
    settle(); advance();
    arv[0] = 0; srv[0] = 1; slast[0] = 1; mrr[0] = 0;
    for (int k = 0; k < 3; k++) begin
      settle(); chk("t5_hold_data", dbg_state[1:0], 2'd2); chk("t5_rready", S0_RREADY, 0);
      chk("t5_rvalid", M0_RVALID, 1); advance();
    end
    mrr[0] = 1;
    settle(); chk("t5_rready_hs", S0_RREADY, 1); advance();
    srv[0] = 0; slast[0] = 0;
    settle(); chk("t5_idle", dbg_state[1:0], 2'd0); advance();

    // 6: reset during the address phase
    reset_dut();
    arv[0] = 1; addr[0] = 32'h80; sarr[0] = 0;
    settle(); advance();
    settle(); chk("t6_addr_arvalid", S0_ARVALID, 1); advance();
    resett = 1'b0;
    settle(); chk("t6_rst_arvalid", S0_ARVALID, 0); chk("t6_rst_arready", M0_ARREADY, 0);
    chk("t6_rst_state", dbg_state, 6'd0); advance();
    resett = 1'b1; arv[0] = 0; arv[1] = 1; addr[1] = 32'h300; sarr[0] = 1;
    settle(); advance();
    settle(); chk("t6_m1_sel", S0_ar_sel, 1); chk("t6_m1_arvalid", S0_ARVALID, 1);
    chk("t6_m1_arready", M1_ARREADY, 1); advance();

    // randomized traffic: disjoint windows, then overlapping windows
    reset_dut();
    random_phase(1500);
    reset_dut();
    r0lo = 32'h800; r0hi = 32'h17FF;
    random_phase(1500);
    reset_dut();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_rd_arbiter_2m2s.md
Name: axi_rd_arbiter_2m2s

Overview:
- Sequences the shared AXI read interconnect between masters M0/M1 and slaves S0/S1.
- Decodes each master's read address against the programmable slave ranges and arbitrates per slave with round-robin priority.
- Steers the AR-channel and R-channel muxes and gates VALID/READY through a per-slave state machine.
- Sits beside the AR/R datapath muxes and drives their select lines. One outstanding read per master and one per slave.

Parameters:
AW, 32, address width of master addresses and range registers
NUM_SLAVES_FIXED, 2, documentation only; the block is fixed at 2x2

Ports:
clkk  in  1  clock
resett  in  1  reset, asynchronous, active-low
slave0_addr1  in  AW  S0 range low bound, inclusive
slave0_addr2  in  AW  S0 range high bound, inclusive
slave1_addr1  in  AW  S1 range low bound, inclusive
slave1_addr2  in  AW  S1 range high bound, inclusive
M0_ARVALID, M1_ARVALID  in  1  master AR valid
M0_ARADDR, M1_ARADDR  in  AW  master AR address
S0_ARREADY, S1_ARREADY  in  1  slave AR ready
S0_RVALID, S1_RVALID  in  1  slave R valid
S0_RLAST, S1_RLAST  in  1  slave R last
M0_RREADY, M1_RREADY  in  1  master R ready
S0_ARVALID, S1_ARVALID  out  1  gated AR valid to slave
S0_ar_sel, S1_ar_sel  out  1  AR mux select for the slave (0=M0, 1=M1)
M0_ARREADY, M1_ARREADY  out  1  gated AR ready to master
M0_r_sel, M1_r_sel  out  1  R mux select for the master (0=S0, 1=S1)
M0_RVALID, M1_RVALID  out  1  gated R valid to master
S0_RREADY, S1_RREADY  out  1  gated R ready to slave
M0_decerr, M1_decerr  out  1  one-cycle pulse: unmapped address dropped

Behaviour:
Reset:
- All state registers go to IDLE and all priority pointers to M0 (0).
- Every output is 0 while resett is low.
- Reset asserted mid-burst aborts the tracking immediately; there is no recovery.

Decode (combinational, per master):
- hit0 = addr1 <= ARADDR <= addr2 for S0; hit1 likewise for S1.
- If both hit, S0 wins. If neither hits, the address is unmapped.

Per-slave FSM (x = 0, 1), states IDLE, ADDR, DATA; owner register own_x:
- IDLE: requesters are masters with ARVALID=1, decoding to Sx, and not busy. A master is busy when any slave FSM is in ADDR or DATA with own = that master.
  - One requester: grant it.
  - Two requesters: grant ptr_x; ptr_x then toggles to the other master.
  - A grant registers own_x and moves to ADDR at the next edge. Arbitration latency is one cycle.
- ADDR:
  - Sx_ar_sel = own_x.
  - Sx_ARVALID = M[own]_ARVALID; M[own]_ARREADY = Sx_ARREADY.
  - On M[own]_ARVALID & Sx_ARREADY, go to DATA.
  - If the master drops ARVALID (protocol violation), hold in ADDR.
- DATA:
  - M[own]_r_sel = x.
  - M[own]_RVALID = Sx_RVALID; Sx_RREADY = M[own]_RREADY.
  - On Sx_RVALID & M[own]_RREADY & Sx_RLAST, return to IDLE. The slave is re-arbitrable in the cycle after the last beat.
- With no owner, all gated signals for that slave/master are 0 and selects are 0.

Unmapped addresses (per master, 2-state DROP FSM):
- Trigger: ARVALID=1, address unmapped, master not busy.
- Next cycle: MX_ARREADY=1 and MX_decerr=1 for exactly one cycle (no R beats are generated). Then return to idle.

Concurrency and boundaries:
- Both slaves may run concurrently with different owners.
- A master is never granted twice.
- The pointer toggles only on contested grants.
- RLAST with RREADY=0 does not terminate the burst.
- RVALID from a slave in IDLE/ADDR is not forwarded and its RREADY stays 0.

Test Plan:
- Reset, then M0 ARVALID with ARADDR=0x100 in S0 range [0x0,0xFFF] -> S0_ARVALID=1 and S0_ar_sel=0 one cycle later. With S0_ARREADY=1, a 4-beat burst follows: M0_RVALID mirrors S0_RVALID, M0_r_sel=0, and the FSM returns to IDLE after the beat with RLAST.
- M0 and M1 both target S1 [0x1000,0x1FFF] in the same cycle -> M0 granted first (ptr=0). Once M0's RLAST handshakes, M1 is granted. On the next contested request M1 wins.
- M0 to S0 and M1 to S1 simultaneously -> both granted in the same cycle. The R bursts interleave independently with correct r_sel values (M0_r_sel=0, M1_r_sel=1).
- M1 ARADDR=0x5000 (unmapped) -> M1_ARREADY=1 and M1_decerr=1 for exactly one cycle; S0/S1_ARVALID stay 0.
- In DATA, S0_RLAST=1 with M0_RREADY=0 for 3 cycles, then 1 -> the FSM stays in DATA until the handshake cycle, then goes IDLE.
- resett pulled low during the ADDR state -> all outputs are 0 immediately. After release a new M1 request is granted normally.
